// File: rtl/route_pkg.sv
// Shared constants, entry layout and enums for the route-table loader.
package route_pkg;

  localparam int ENTRY_WIDTH = 256;
  localparam int WORD_WIDTH  = 32;
  localparam int WPE         = ENTRY_WIDTH / WORD_WIDTH;
  localparam int WIDX_W      = $clog2(WPE);
  localparam int ADDR_W      = 6;
  localparam int CNT_W       = 7;
  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  // Field offsets inside one fpga_dest_entry_t
  localparam int DST_IP_LSB        = 0;
  localparam int DST_IP_W          = 32;
  localparam int VALID_BIT         = 32;
  localparam int DIRECT_HOST_BIT   = 40;
  localparam int BROADCAST_BIT     = 48;
  localparam int DEFAULT_ROUTE_BIT = 56;

  typedef logic [ENTRY_WIDTH-1:0] fpga_dest_entry_t;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_BAD_HEADER   = 2'd1,
    ERR_EARLY_LAST   = 2'd2,
    ERR_MISSING_LAST = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_COLLECT,
    ST_WRITE,
    ST_CLEAR,
    ST_DONE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/route_table_loader_assembler.sv
// Gathers WPE stream words (least-significant first) into one table entry.
module route_table_loader_assembler
  import route_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  zero_out,
  input  logic                  word_wr,
  input  logic [WORD_WIDTH-1:0] word_in,
  output fpga_dest_entry_t      entry_data,
  output logic [WIDX_W-1:0]     word_idx,
  output logic                  full
);

  logic [ENTRY_WIDTH-WORD_WIDTH-1:0] asm_q;
  fpga_dest_entry_t                  entry_q;

  assign full       = (word_idx == WIDX_W'(WPE - 1));
  assign entry_data = entry_q;

  // The final word goes straight into the output register, so the entry
  // presented to the table only changes when a complete entry is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q    <= '0;
      entry_q  <= '0;
      word_idx <= '0;
    end else begin
      if (clr) begin
        word_idx <= '0;
      end else if (word_wr) begin
        word_idx <= word_idx + WIDX_W'(1);
        if (full) begin
          entry_q <= {word_in, asm_q};
        end else begin
          asm_q[word_idx*WORD_WIDTH +: WORD_WIDTH] <= word_in;
        end
      end
      if (zero_out) begin
        entry_q <= '0;
      end
    end
  end

endmodule

// File: rtl/route_table_loader.sv
// Streams a header plus N entries into the route searcher table, then clears the rest.
module route_table_loader
  import route_pkg::*;
#(
  parameter int MAX_ENTRIES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   init_mode,
  output logic [ENTRY_WIDTH-1:0] init_entry_data,
  output logic [ADDR_W-1:0]      init_entry_addr,
  output logic                   init_entry_wr,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [CNT_W-1:0]       entries_loaded
);

  localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_ENTRIES);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MAX_ENTRIES - 1);

  state_e            state, state_d;
  err_code_e         err_q, err_d;
  logic [CNT_W-1:0]  n_q, entry_idx, loaded_q, hdr_n;
  logic [WIDX_W-1:0] word_idx;
  logic              word_full, accept, hdr_ok, final_entry;
  logic              asm_clr, asm_zero, asm_wr;

  assign accept      = s_valid && s_ready;
  assign hdr_n       = s_data[CNT_W-1:0];
  assign hdr_ok      = (s_data[31:16] == HDR_MAGIC) && (hdr_n != '0) && (hdr_n <= MAX_N);
  assign final_entry = (entry_idx == n_q - CNT_W'(1));
  assign asm_wr      = (state == ST_COLLECT) && s_valid;

  route_table_loader_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .zero_out  (asm_zero),
    .word_wr   (asm_wr),
    .word_in   (s_data),
    .entry_data(init_entry_data),
    .word_idx  (word_idx),
    .full      (word_full)
  );

  always_comb begin
    state_d  = state;
    err_d    = err_q;
    asm_clr  = 1'b0;
    asm_zero = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_d = ST_HEADER;
        err_d   = ERR_NONE;
        asm_clr = 1'b1;
      end
      ST_HEADER: if (accept) begin
        if (hdr_ok && !s_last) begin
          state_d = ST_COLLECT;
        end else begin
          err_d   = ERR_BAD_HEADER;
          state_d = s_last ? ST_DONE : ST_DRAIN;
        end
      end
      ST_COLLECT: if (accept) begin
        if (!word_full) begin
          if (s_last) begin
            err_d   = ERR_EARLY_LAST;
            state_d = ST_DONE;
          end
        end else if (s_last && !final_entry) begin
          err_d   = ERR_EARLY_LAST;
          state_d = ST_DONE;
        end else begin
          // A complete final entry without s_last is still written, then drained
          if (!s_last && final_entry) err_d = ERR_MISSING_LAST;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!final_entry) begin
          state_d = ST_COLLECT;
        end else if (err_q == ERR_MISSING_LAST) begin
          state_d = ST_DRAIN;
        end else if (n_q < MAX_N) begin
          state_d  = ST_CLEAR;
          asm_zero = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CLEAR: if (entry_idx == LAST_ADDR) state_d = ST_DONE;
      ST_DRAIN: if (accept && s_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err_q     <= ERR_NONE;
      n_q       <= '0;
      entry_idx <= '0;
      loaded_q  <= '0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      case (state)
        ST_IDLE: if (start) begin
          entry_idx <= '0;
          loaded_q  <= '0;
        end
        ST_HEADER: if (accept && hdr_ok && !s_last) begin
          n_q       <= hdr_n;
          entry_idx <= '0;
        end
        ST_WRITE: begin
          entry_idx <= entry_idx + CNT_W'(1);
          loaded_q  <= loaded_q + CNT_W'(1);
        end
        ST_CLEAR: if (entry_idx != LAST_ADDR) entry_idx <= entry_idx + CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign s_ready         = (state == ST_HEADER) || (state == ST_COLLECT) || (state == ST_DRAIN);
  assign init_mode       = (state != ST_IDLE) && (state != ST_DONE);
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);
  assign error           = done && (err_q != ERR_NONE);
  assign err_code        = err_q;
  assign init_entry_wr   = (state == ST_WRITE) || (state == ST_CLEAR);
  assign init_entry_addr = entry_idx[ADDR_W-1:0];
  assign entries_loaded  = loaded_q;

endmodule

// File: tb/tb_route_table_loader.sv
// Directed scoreboard bench for route_table_loader: expected writes queued at stimulus time.
module tb_route_table_loader;
  import route_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start, s_valid, s_last;
  logic [31:0]  s_data;
  logic         s_ready, init_mode, init_entry_wr, busy, done, error;
  logic [255:0] init_entry_data;
  logic [5:0]   init_entry_addr;
  logic [1:0]   err_code;
  logic [6:0]   entries_loaded;

  typedef struct packed {
    logic [5:0]   addr;
    logic [255:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_compared = 0;
  int  n_mismatched = 0;
  int  wr_count = 0;
  int  init_gap = 0;

  route_table_loader #(.MAX_ENTRIES(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .init_mode      (init_mode),
    .init_entry_data(init_entry_data),
    .init_entry_addr(init_entry_addr),
    .init_entry_wr  (init_entry_wr),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .entries_loaded (entries_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard on every table write and watches the init_mode window
  always @(negedge clk) begin
    wr_t exp_w;
    if (!rst && init_entry_wr) begin
      wr_count++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_write", 256'(init_entry_addr), 256'h1ff);
      end else begin
        exp_w = sb_q.pop_front();
        checkOutput("wr_addr", 256'(init_entry_addr), 256'(exp_w.addr));
        checkOutput("wr_data", init_entry_data, exp_w.data);
      end
    end
    if (!rst && busy && !done && !init_mode) init_gap++;
  end

  task automatic applyStimulus(input logic [31:0] w, input logic last, input bit gap);
    int b = 0;
    s_data  = w;
    s_last  = last;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) checkOutput("handshake_timeout", 256'(b), 256'd0);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic sendEntry(input logic [255:0] ent, input logic last, input bit gap, input logic [5:0] addr);
    sb_q.push_back('{addr: addr, data: ent});
    for (int k = 0; k < 8; k++) applyStimulus(ent[k*32 +: 32], last && (k == 7), gap);
  endtask

  task automatic pushClears(input int from_addr);
    for (int a = from_addr; a < 64; a++) sb_q.push_back('{addr: 6'(a), data: '0});
  endtask

  task automatic startLoad(input logic [31:0] hdr, input logic hdr_last);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("init_mode_after_start", 256'(init_mode), 256'd1);
    applyStimulus(hdr, hdr_last, 1'b0);
  endtask

  task automatic waitDone(input string tag);
    int b = 0;
    while (done !== 1'b1 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    checkOutput({tag, "_done"}, 256'(done), 256'd1);
  endtask

  task automatic expectResult(input string tag, input logic err, input logic [1:0] code, input logic [6:0] loaded);
    checkOutput({tag, "_error"}, 256'(error), 256'(err));
    checkOutput({tag, "_err_code"}, 256'(err_code), 256'(code));
    checkOutput({tag, "_loaded"}, 256'(entries_loaded), 256'(loaded));
    checkOutput({tag, "_init_mode_at_done"}, 256'(init_mode), 256'd0);
    checkOutput({tag, "_sb_empty"}, 256'(sb_q.size()), 256'd0);
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, 256'(busy), 256'd0);
    checkOutput({tag, "_done_pulse"}, 256'(done), 256'd0);
    checkOutput({tag, "_err_code_hold"}, 256'(err_code), 256'(code));
    checkOutput({tag, "_loaded_hold"}, 256'(entries_loaded), 256'(loaded));
  endtask

  initial begin
    logic [255:0] ent;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", 256'(s_ready), 256'd0);
    checkOutput("rst_init_mode", 256'(init_mode), 256'd0);
    checkOutput("rst_busy", 256'(busy), 256'd0);
    checkOutput("rst_wr", 256'(init_entry_wr), 256'd0);
    checkOutput("rst_data", init_entry_data, 256'd0);
    checkOutput("rst_loaded", 256'(entries_loaded), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] test 1: N=2 load with clears");
    wr_count = 0;
    startLoad(32'hA55A0002, 1'b0);
    sendEntry({192'd0, 32'h1, 32'h0A000001}, 1'b0, 1'b0, 6'd0);
    sendEntry({192'd0, 32'h1, 32'h0A000002}, 1'b1, 1'b0, 6'd1);
    pushClears(2);
    waitDone("t1");
    checkOutput("t1_wr_count", 256'(wr_count), 256'd64);
    expectResult("t1", 1'b0, 2'd0, 7'd2);
    checkOutput("t1_init_window", 256'(init_gap), 256'd0);
    $display("[TB] test 2: bad magic drains to s_last");
    wr_count = 0;
    startLoad(32'h12340002, 1'b0);
    checkOutput("t2_drain_ready", 256'(s_ready), 256'd1);
    applyStimulus(32'h11111111, 1'b0, 1'b0);
    applyStimulus(32'h22222222, 1'b0, 1'b0);
    checkOutput("t2_not_done_yet", 256'(done), 256'd0);
    applyStimulus(32'h33333333, 1'b1, 1'b0);
    waitDone("t2");
    checkOutput("t2_wr_count", 256'(wr_count), 256'd0);
    expectResult("t2", 1'b1, 2'd1, 7'd0);
    $display("[TB] test 2b: N=0 header with s_last, N=65 header");
    startLoad(32'hA55A0000, 1'b1);
    checkOutput("t2b_done_next", 256'(done), 256'd1);
    expectResult("t2b", 1'b1, 2'd1, 7'd0);
    startLoad(32'hA55A0041, 1'b0);
    applyStimulus(32'h0, 1'b1, 1'b0);
    waitDone("t2c");
    expectResult("t2c", 1'b1, 2'd1, 7'd0);
    $display("[TB] test 3: early s_last");
    startLoad(32'hA55A0002, 1'b0);
    sendEntry({192'd0, 32'h1, 32'hC0A80001}, 1'b0, 1'b0, 6'd0);
    ent = {192'd0, 32'h1, 32'hC0A80002};
    for (int k = 0; k < 6; k++) applyStimulus(ent[k*32 +: 32], k == 5, 1'b0);
    checkOutput("t3_done_next", 256'(done), 256'd1);
    expectResult("t3", 1'b1, 2'd2, 7'd1);
    $display("[TB] test 4: missing s_last");
    startLoad(32'hA55A0001, 1'b0);
    sendEntry({32'hDEADBEEF, 160'd0, 32'h1, 32'h0A0000FF}, 1'b0, 1'b0, 6'd0);
    applyStimulus(32'hAAAA0001, 1'b0, 1'b0);
    applyStimulus(32'hAAAA0002, 1'b0, 1'b0);
    checkOutput("t4_not_done_yet", 256'(done), 256'd0);
    applyStimulus(32'hAAAA0003, 1'b1, 1'b0);
    checkOutput("t4_done_next", 256'(done), 256'd1);
    expectResult("t4", 1'b1, 2'd3, 7'd1);
    $display("[TB] test 5: N=64 full load, gapped valid");
    wr_count = 0;
    startLoad(32'hA55A0040, 1'b0);
    for (int e = 0; e < 64; e++) begin
      for (int k = 0; k < 8; k++) ent[k*32 +: 32] = $urandom();
      sendEntry(ent, e == 63, 1'b1, 6'(e));
    end
    waitDone("t5");
    checkOutput("t5_wr_count", 256'(wr_count), 256'd64);
    expectResult("t5", 1'b0, 2'd0, 7'd64);
    $display("[TB] test 6: reset during entry 3");
    wr_count = 0;
    startLoad(32'hA55A0005, 1'b0);
    for (int e = 0; e < 3; e++) sendEntry({224'(e + 1), 32'h0A000010}, 1'b0, 1'b0, 6'(e));
    applyStimulus(32'h0A000099, 1'b0, 1'b0);
    applyStimulus(32'h1, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_init_mode", 256'(init_mode), 256'd0);
    checkOutput("t6_busy", 256'(busy), 256'd0);
    checkOutput("t6_s_ready", 256'(s_ready), 256'd0);
    checkOutput("t6_wr", 256'(init_entry_wr), 256'd0);
    checkOutput("t6_data_cleared", init_entry_data, 256'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_wr_count", 256'(wr_count), 256'd3);
    checkOutput("t6_sb_empty", 256'(sb_q.size()), 256'd0);
    startLoad(32'hA55A0001, 1'b0);
    sendEntry({192'd0, 32'h1, 32'h0A0000AA}, 1'b1, 1'b0, 6'd0);
    pushClears(1);
    waitDone("t6");
    expectResult("t6", 1'b0, 2'd0, 7'd1);
    checkOutput("final_init_window", 256'(init_gap), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
